bsg_wrr_n_to_1: RTL and testbench

BSG_WRR_N_TO_1 -- requirements
Module: bsg_wrr_n_to_1

---
 rtl/bsg_wrr_pkg.sv | 14 +
 rtl/bsg_rr_next_valid.sv | 30 +++
 rtl/bsg_wrr_n_to_1.sv | 94 +++++++++
 tb/tb_bsg_wrr_n_to_1.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_wrr_pkg.sv
// Shared defaults and helpers for the weighted round-robin arbiter.
package bsg_wrr_pkg;

    localparam int num_in_default_p       = 8;
    localparam int width_default_p        = 32;
    localparam int weight_width_default_p = 4;
    localparam int tag_width_default_p    = $clog2(num_in_default_p);

    // Tag width for a given requester count; never narrower than one bit.
    function automatic int tag_width(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/bsg_rr_next_valid.sv
// Rotating search for the first valid requester after the current grant.
// The search order is grant+1, grant+2, ... wrapping, and ends at grant
// itself. With no requester valid the current grant is returned.
module bsg_rr_next_valid
    import bsg_wrr_pkg::*;
#(
    parameter  int num_in_p     = num_in_default_p,
    localparam int tag_width_lp = tag_width(num_in_p)
) (
    input  logic [num_in_p-1:0]     v_i,
    input  logic [tag_width_lp-1:0] grant_i,
    output logic [tag_width_lp-1:0] next_o
);

    int idx;

    // Walk from the farthest offset down to the nearest so the nearest valid
    // requester is the last assignment and therefore wins.
    always_comb begin
        next_o = grant_i;
        idx    = 0;
        for (int k = num_in_p; k >= 1; k--) begin
            idx = (int'(grant_i) + k) % num_in_p;
            if (v_i[idx]) begin
                next_o = tag_width_lp'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_wrr_n_to_1.sv
// Weighted round-robin N-to-1 arbiter. The granted requester keeps the grant
// for a burst of up to its weight accepted transfers, then the grant rotates
// to the next valid requester. A stored weight of 0 behaves as weight 1.
//
// Handshake: v_o/data_o/tag_o describe the granted requester every cycle;
// a transfer happens on a cycle where v_o=1 and yumi_i=1, and yumi_o then
// pulses one-hot to the granted requester. yumi_i must not be raised while
// v_o=0.
module bsg_wrr_n_to_1
    import bsg_wrr_pkg::*;
#(
    parameter int num_in_p       = num_in_default_p,
    parameter int width_p        = width_default_p,
    parameter int weight_width_p = weight_width_default_p
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]           v_i,
    output logic [num_in_p-1:0]           yumi_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    output logic [tag_width(num_in_p)-1:0] tag_o,
    input  logic                          yumi_i,
    input  logic                          cfg_v_i,
    input  logic [tag_width(num_in_p)-1:0] cfg_addr_i,
    input  logic [weight_width_p-1:0]     cfg_weight_i
);

    localparam int tag_width_lp = tag_width(num_in_p);

    logic [tag_width_lp-1:0]   grant_r;
    logic [tag_width_lp-1:0]   next_valid;
    logic [weight_width_p-1:0] count_r;
    logic [weight_width_p-1:0] weight_r [num_in_p];

    // One extra bit so a full-scale weight yields exactly that many grants.
    logic [weight_width_p:0]   count_plus;
    logic [weight_width_p:0]   eff_weight;
    logic                      any_v;

    bsg_rr_next_valid #(
        .num_in_p (num_in_p)
    ) next_valid_search (
        .v_i     (v_i),
        .grant_i (grant_r),
        .next_o  (next_valid)
    );

    assign any_v      = |v_i;
    assign tag_o      = grant_r;
    assign v_o        = v_i[grant_r];
    assign data_o     = data_i[grant_r*width_p +: width_p];
    assign yumi_o     = num_in_p'(yumi_i) << grant_r;
    assign count_plus = {1'b0, count_r} + (weight_width_p+1)'(1);
    assign eff_weight = (weight_r[grant_r] == '0) ? (weight_width_p+1)'(1)
                                                  : {1'b0, weight_r[grant_r]};

    // Grant and burst counter: skip an idle grant, extend or end a burst.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_r <= '0;
            count_r <= '0;
        end else if (any_v) begin
            if (!v_o) begin
                grant_r <= next_valid;
                count_r <= '0;
            end else if (yumi_i) begin
                if (count_plus < eff_weight) begin
                    count_r <= count_plus[weight_width_p-1:0];
                end else begin
                    grant_r <= next_valid;
                    count_r <= '0;
                end
            end
        end
    end

    // Weight table; a write takes effect from the following cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_in_p; i++) begin
                weight_r[i] <= weight_width_p'(1);
            end
        end else if (cfg_v_i) begin
            weight_r[cfg_addr_i] <= cfg_weight_i;
        end
    end

    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_bsg_wrr_n_to_1.sv
// Self-checking bench for the weighted round-robin arbiter.
module tb_bsg_wrr_n_to_1;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int WW = 4;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*W-1:0]  data_i = '0;
    logic [N-1:0]    v_i = '0;
    logic [N-1:0]    yumi_o;
    logic            v_o;
    logic [W-1:0]    data_o;
    logic [TW-1:0]   tag_o;
    logic            yumi_i = 1'b0;
    logic            cfg_v_i = 1'b0;
    logic [TW-1:0]   cfg_addr_i = '0;
    logic [WW-1:0]   cfg_weight_i = '0;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;
    int acc_q[$];

    // Reference state: who holds the grant, how many transfers it has had in
    // this burst, and the programmed weights.
    int m_grant = 0;
    int m_used = 0;
    int m_weight[N] = '{default: 1};

    bsg_wrr_n_to_1 #(.num_in_p(N), .width_p(W), .weight_width_p(WW)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .data_i       (data_i),
        .v_i          (v_i),
        .yumi_o       (yumi_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .tag_o        (tag_o),
        .yumi_i       (yumi_i),
        .cfg_v_i      (cfg_v_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_weight_i (cfg_weight_i)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int next_of(input int g, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(g + k) % N]) return (g + k) % N;
        end
        return g;
    endfunction

    function automatic int eff_of(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [N-1:0] exp_yumi(input logic y, input int g);
        logic [N-1:0] one;
        one = 1;
        return y ? (one << g) : '0;
    endfunction

    // Reference model update on each clock edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_grant <= 0;
            m_used  <= 0;
            for (int i = 0; i < N; i++) m_weight[i] <= 1;
        end else begin
            if (cfg_v_i) m_weight[int'(cfg_addr_i)] <= int'(cfg_weight_i);
            if (v_i != '0) begin
                if (!v_i[m_grant]) begin
                    m_grant <= next_of(m_grant, v_i);
                    m_used  <= 0;
                end else if (yumi_i) begin
                    if (m_used + 1 < eff_of(m_weight[m_grant])) begin
                        m_used <= m_used + 1;
                    end else begin
                        m_grant <= next_of(m_grant, v_i);
                        m_used  <= 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare outputs against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            check("tag", 64'(tag_o), 64'(m_grant));
            check("v_o", 64'(v_o), 64'(v_i[m_grant]));
            check("data", 64'(data_o), 64'(data_i[m_grant*W +: W]));
            check("yumi_o", 64'(yumi_o), 64'(exp_yumi(yumi_i, m_grant)));
            if (reset_n && v_o && yumi_i) acc_q.push_back(int'(tag_o));
        end
    end

    task automatic check_seq(input string name, input int exp[$]);
        check({name, "_len"}, 64'(acc_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < acc_q.size()) ? 64'(acc_q[i]) : 64'hFFFF, 64'(exp[i]));
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) data_i[i*W +: W] = $urandom;
    endtask

    // One clock cycle of stimulus; yumi is only offered when the model says
    // the granted requester is valid.
    task automatic cycle(input logic [N-1:0] v, input bit want_yumi,
                         input bit cfg, input int addr, input int w);
        v_i          = v;
        randomize_data();
        yumi_i       = want_yumi && v[m_grant] && reset_n;
        cfg_v_i      = cfg;
        cfg_addr_i   = TW'(addr);
        cfg_weight_i = WW'(w);
        @(posedge clk);
        #1;
        cfg_v_i = 1'b0;
        yumi_i  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        yumi_i  = 1'b0;
        cfg_v_i = 1'b0;
        v_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc_q.delete();
    endtask

    initial begin
        int e[$];
        int a2;
        int guard;

        // Reset defaults observed during reset.
        reset_n = 1'b0;
        v_i = 8'h01;
        @(posedge clk);
        started = 1'b1;
        #1;
        check("reset_tag", 64'(tag_o), 64'd0);
        check("reset_v_o", 64'(v_o), 64'd1);
        check("reset_yumi_o", 64'(yumi_o), 64'd0);

        // Plain round robin out of reset.
        do_reset();
        repeat (9) cycle(8'hFF, 1, 0, 0, 0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        check_seq("rr_default", e);

        // Weighted bursts.
        do_reset();
        cycle(8'h00, 0, 1, 0, 3);
        cycle(8'h00, 0, 1, 2, 2);
        repeat (12) cycle(8'hFF, 1, 0, 0, 0);
        e = '{0, 0, 0, 1, 2, 2, 3, 4, 5, 6, 7, 0};
        check_seq("weighted", e);

        // Sparse valids: one bubble, then 4 and 7 alternate.
        do_reset();
        v_i = 8'h90;
        #1;
        check("sparse_bubble", 64'(v_o), 64'd0);
        repeat (5) cycle(8'h90, 1, 0, 0, 0);
        e = '{4, 7, 4, 7};
        check_seq("sparse", e);

        // Requester 2 drops after two of its four grants.
        do_reset();
        cycle(8'h00, 0, 1, 2, 4);
        a2 = 0;
        for (int c = 0; c < 8; c++) begin
            if (a2 >= 2) begin
                cycle(8'hFB, 1, 0, 0, 0);
            end else begin
                if (m_grant == 2) a2++;
                cycle(8'hFF, 1, 0, 0, 0);
            end
        end
        e = '{0, 1, 2, 2, 3, 4, 5};
        check_seq("drop_mid_burst", e);

        // Weight rewrite on the second transfer of a weight-3 burst.
        do_reset();
        cycle(8'h00, 0, 1, 0, 3);
        cycle(8'hFF, 1, 0, 0, 0);
        cycle(8'hFF, 1, 1, 0, 1);
        repeat (10) cycle(8'hFF, 1, 0, 0, 0);
        e = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        check_seq("cfg_same_cycle", e);

        // Full-scale weight gives exactly 15 grants; weight 0 behaves as 1.
        do_reset();
        cycle(8'h00, 0, 1, 0, 15);
        cycle(8'h00, 0, 1, 1, 0);
        repeat (17) cycle(8'hFF, 1, 0, 0, 0);
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
        check_seq("weight_max", e);

        // Reset in the middle of requester 5's burst.
        do_reset();
        for (int i = 0; i < N; i++) cycle(8'h00, 0, 1, i, 2);
        guard = 0;
        while (!(m_grant == 5 && m_used == 1) && guard < 40) begin
            cycle(8'hFF, 1, 0, 0, 0);
            guard++;
        end
        check("mid_burst_reached", 64'(guard < 40), 64'd1);
        v_i = 8'hFF;
        reset_n = 1'b0;
        #1;
        check("reset_mid_tag", 64'(tag_o), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc_q.delete();
        repeat (9) cycle(8'hFF, 1, 0, 0, 0);
        e = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        check_seq("after_reset_rr", e);

        // Randomized traffic, weights and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : N'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                v_i = v;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
            cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, N-1), $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
